// File: rtl/glbl_seq_pkg.sv
// ============================================================================
// Module   : glbl_seq_pkg
// Summary  : State codes and output decode shared by the GSR/GTS sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package glbl_seq_pkg;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [ST_W-1:0] ST_HOLD_GSR  = 2'd1;
    localparam logic [ST_W-1:0] ST_HOLD_GTS  = 2'd2;
    localparam logic [ST_W-1:0] ST_RUN       = 2'd3;

    typedef enum logic [ST_W-1:0] {
        S_WAIT_LOCK = ST_WAIT_LOCK,
        S_HOLD_GSR  = ST_HOLD_GSR,
        S_HOLD_GTS  = ST_HOLD_GTS,
        S_RUN       = ST_RUN
    } state_e;

    typedef struct packed {
        logic gsr;
        logic gts;
        logic ready;
        logic busy;
    } outs_t;

    // Moore decode of a state into the four status/control outputs.
    function automatic outs_t decode_outs(state_e s);
        outs_t o;
        o = '{gsr: 1'b1, gts: 1'b1, ready: 1'b0, busy: 1'b1};
        case (s)
            S_HOLD_GTS: o = '{gsr: 1'b0, gts: 1'b1, ready: 1'b0, busy: 1'b1};
            S_RUN:      o = '{gsr: 1'b0, gts: 1'b0, ready: 1'b1, busy: 1'b0};
            default:    o = '{gsr: 1'b1, gts: 1'b1, ready: 1'b0, busy: 1'b1};
        endcase
        return o;
    endfunction

endpackage

`default_nettype wire

// File: rtl/glbl_seq_if.sv
// ============================================================================
// Module   : glbl_seq_if
// Summary  : Lock/restart inputs and GSR/GTS/status outputs of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface glbl_seq_if;
    import glbl_seq_pkg::*;

    logic            locked;
    logic            restart;
    logic            gsr;
    logic            gts;
    logic            ready;
    logic            busy;
    logic [ST_W-1:0] state;

    modport master (
        output locked,
        output restart,
        input  gsr,
        input  gts,
        input  ready,
        input  busy,
        input  state
    );

    modport slave (
        input  locked,
        input  restart,
        output gsr,
        output gts,
        output ready,
        output busy,
        output state
    );
endinterface

`default_nettype wire

// File: rtl/glbl_seq_phase_cnt.sv
// ============================================================================
// Module   : glbl_seq_phase_cnt
// Summary  : Shared phase counter with clear/enable and terminal-count compare.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module glbl_seq_phase_cnt #(
    parameter int CNT_WIDTH = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 clr_i,
    input  wire logic                 en_i,
    input  wire logic [CNT_WIDTH-1:0] limit_i,
    output logic                      tc_o
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Limit is a cycle count, so the last cycle of a phase is limit-1.
    assign tc_o = (cnt_q == (limit_i - CNT_WIDTH'(1)));

endmodule

`default_nettype wire

// File: rtl/glbl_seq.sv
// ============================================================================
// Module   : glbl_seq
// Summary  : Power-up/restart sequencer releasing GSR then GTS after clock lock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module glbl_seq
    import glbl_seq_pkg::*;
#(
    parameter int LOCK_CYCLES  = 16,
    parameter int GSR_CYCLES   = 8,
    parameter int GTS_CYCLES   = 4,
    parameter bit RELOCK_RESEQ = 1'b1,
    parameter int CNT_WIDTH    = 16
) (
    input  wire logic clk,
    input  wire logic rst_n,
    glbl_seq_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] C_LOCK_LIM = CNT_WIDTH'(LOCK_CYCLES);
    localparam logic [CNT_WIDTH-1:0] C_GSR_LIM  = CNT_WIDTH'(GSR_CYCLES);
    localparam logic [CNT_WIDTH-1:0] C_GTS_LIM  = CNT_WIDTH'(GTS_CYCLES);

    state_e               state_q;
    state_e               state_d;
    outs_t                outs_q;
    logic                 cnt_clr;
    logic                 cnt_en;
    logic                 cnt_tc;
    logic [CNT_WIDTH-1:0] cnt_limit;

    glbl_seq_phase_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_phase_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .limit_i (cnt_limit),
        .tc_o    (cnt_tc)
    );

    always_comb begin
        state_d   = state_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        cnt_limit = C_LOCK_LIM;

        case (state_q)
            S_HOLD_GSR: cnt_limit = C_GSR_LIM;
            S_HOLD_GTS: cnt_limit = C_GTS_LIM;
            default:    cnt_limit = C_LOCK_LIM;
        endcase

        // Lock loss outranks restart, which outranks phase completion.
        if (!bus.locked) begin
            if (!(state_q == S_RUN && !RELOCK_RESEQ && !bus.restart)) begin
                state_d = S_WAIT_LOCK;
                cnt_clr = 1'b1;
            end
        end else if (bus.restart) begin
            state_d = S_HOLD_GSR;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                S_WAIT_LOCK: begin
                    if (cnt_tc) begin
                        state_d = S_HOLD_GSR;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                S_HOLD_GSR: begin
                    if (cnt_tc) begin
                        state_d = S_HOLD_GTS;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                S_HOLD_GTS: begin
                    if (cnt_tc) begin
                        state_d = S_RUN;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                default: begin
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    // Outputs register the decode of the next state so they move with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT_LOCK;
            outs_q  <= '{gsr: 1'b1, gts: 1'b1, ready: 1'b0, busy: 1'b1};
        end else begin
            state_q <= state_d;
            outs_q  <= decode_outs(state_d);
        end
    end

    assign bus.gsr   = outs_q.gsr;
    assign bus.gts   = outs_q.gts;
    assign bus.ready = outs_q.ready;
    assign bus.busy  = outs_q.busy;
    assign bus.state = state_q;

endmodule

`default_nettype wire
